// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM states and the ALU saturation constants.
package alu_pkg;

    localparam int DIV_W = 16;

    localparam logic [DIV_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [DIV_W-1:0] SAT_NEG = 16'h8000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract |divisor|,
// keep the difference and set the new quotient bit when it is non-negative.
module div_step
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH:0]   dmag,
    output logic [WIDTH:0]   rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // Shift, trial-subtract, restore on borrow.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dmag};
        if (!diff[WIDTH+1]) begin
            rem_nxt = diff[WIDTH:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[WIDTH:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq_16bit.sv
// Multi-cycle signed saturating divider (restoring, one quotient bit per cycle).
// Optional build macro DIV_EARLY_OUT_EN: divisor==1 and dividend==0 finish
// straight from PREP instead of running the full iteration.
module div_seq_16bit
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    // Saturated quotient for a clamped result of the given sign.
    function automatic logic [WIDTH-1:0] sat_quot(input logic neg);
        return neg ? WIDTH'(SAT_NEG) : WIDTH'(SAT_POS);
    endfunction

    // Magnitude of a two's-complement value; MIN maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    // Re-apply a sign to an unsigned magnitude.
    function automatic logic [WIDTH-1:0] apply_sign(input logic neg, input logic [WIDTH-1:0] m);
        return neg ? WIDTH'(-m) : m;
    endfunction

    div_state_t state, state_nxt;

    logic signed [WIDTH-1:0] a_r;
    logic signed [WIDTH-1:0] b_r;
    logic                    neg_q;
    logic                    neg_r;
    logic [WIDTH:0]          rem_r;
    logic [WIDTH-1:0]        quo_r;
    logic [WIDTH:0]          dmag_r;
    logic [CNT_W-1:0]        cnt;

    logic [WIDTH:0]          rem_nxt;
    logic [WIDTH-1:0]        quo_nxt;

    logic                    is_dz;
    logic                    is_ovf;
    logic                    early;
    logic                    accept;

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign is_dz  = (b_r == '0);
    assign is_ovf = (a_r == WIDTH'(SAT_NEG)) && (b_r == '1);

`ifdef DIV_EARLY_OUT_EN
    assign early = (a_r == '0) || (b_r == WIDTH'(1));
`else
    assign early = 1'b0;
`endif

    assign busy = (state == PREP) || (state == ITER) || (state == FIX);
    assign done = (state == DONE);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem_r),
        .quo     (quo_r),
        .dmag    (dmag_r),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = PREP;
            PREP: state_nxt = (is_dz || is_ovf || early) ? DONE : ITER;
            ITER: if (cnt == LAST_ITER) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = start ? PREP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and result/flag registers; results change only on entry to DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == PREP) begin
                if (is_dz) begin
                    quotient  <= sat_quot(a_r[WIDTH-1]);
                    remainder <= a_r;
                    div_zero  <= 1'b1;
                    overflow  <= 1'b0;
                end else if (is_ovf) begin
                    quotient  <= sat_quot(1'b0);
                    remainder <= '0;
                    div_zero  <= 1'b0;
                    overflow  <= 1'b1;
                end else begin
                    // Both early-out cases (x/1 and 0/x) have q = dividend, r = 0.
                    if (early) begin
                        quotient  <= a_r;
                        remainder <= '0;
                    end
                    div_zero <= 1'b0;
                    overflow <= 1'b0;
                end
            end else if (state == FIX) begin
                quotient  <= apply_sign(neg_q, quo_r);
                remainder <= apply_sign(neg_r, rem_r[WIDTH-1:0]);
            end
        end
    end

    // Operand capture, magnitude setup and iteration datapath (no reset needed).
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r <= dividend;
            b_r <= divisor;
        end
        case (state)
            PREP: begin
                neg_q  <= a_r[WIDTH-1] ^ b_r[WIDTH-1];
                neg_r  <= a_r[WIDTH-1];
                rem_r  <= '0;
                quo_r  <= mag(a_r);
                dmag_r <= {1'b0, mag(b_r)};
                cnt    <= '0;
            end
            ITER: begin
                rem_r <= rem_nxt;
                quo_r <= quo_nxt;
                cnt   <= cnt + 1'b1;
            end
            default: ;
        endcase
    end

endmodule
